// File: rtl/rv32i_types.sv
// Shared RV32I core types: machine word, fetch FSM states and the
// {pc, instr} record carried from fetch to decode.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_entry_t;

    // Word-align a control-flow target.
    function automatic rv32i_word align_word(input rv32i_word addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, instr} records. Flush empties the
// queue and wins over push and pop in the same cycle. The head outputs read
// registered storage directly so decode never sees a combinational path
// from the memory response.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(QDEPTH+1)-1:0]  count,
    output logic                         head_valid,
    output fetch_entry_t                 head_entry
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    fetch_entry_t   mem [QDEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count != '0);

    // Storage, pointers and occupancy; reset clears the head storage too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_valid = (count != '0);
    assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one memory
// request outstanding, and feeds decode from fetch_queue.
//
//   state | meaning
//   IDLE  | no request outstanding; waiting for queue space
//   REQ   | request at fetch_pc outstanding; its response will be kept
//   DROP  | squashed request outstanding; hold its address, discard data
module fetch_stage
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h0000_0060,
    parameter int        QDEPTH   = 2
) (
    input  logic      clk,
    input  logic      rst,
    output logic      imem_read,
    output rv32i_word imem_address,
    input  logic      imem_resp,
    input  rv32i_word imem_rdata,
    input  logic      redirect,
    input  rv32i_word redirect_pc,
    input  logic      stall,
    output logic      if_valid,
    output rv32i_word if_instr,
    output rv32i_word if_pc
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t   state;
    fetch_state_t   state_next;
    rv32i_word      fetch_pc;
    rv32i_word      pc_next;
    rv32i_word      squash_addr;
    rv32i_word      squash_next;
    rv32i_word      redirect_tgt;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           has_space;
    logic           push;
    logic           pop;
    fetch_entry_t   push_entry;
    fetch_entry_t   head_entry;

    assign redirect_tgt = align_word(redirect_pc);
    assign pop          = if_valid & ~stall;
    assign push         = imem_resp & (state == REQ) & ~redirect;
    assign count_next   = redirect ? '0 : count + CW'(push) - CW'(pop);
    // A new request is only issued when its response is guaranteed a slot.
    assign has_space    = (count_next < CW'(QDEPTH));
    assign push_entry   = '{pc: fetch_pc, instr: imem_rdata};

    assign imem_read    = (state != IDLE);
    assign imem_address = (state == DROP) ? squash_addr : fetch_pc;

    // State, fetch PC and squashed-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            squash_addr <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= pc_next;
            squash_addr <= squash_next;
        end
    end

    // Next-state and next fetch PC; a redirect always wins over the response.
    always_comb begin
        state_next  = state;
        pc_next     = fetch_pc;
        squash_next = squash_addr;
        case (state)
            IDLE: begin
                if (redirect) pc_next = redirect_tgt;
                if (has_space) state_next = REQ;
            end
            REQ: begin
                if (imem_resp) begin
                    pc_next    = redirect ? redirect_tgt : fetch_pc + 32'd4;
                    state_next = has_space ? REQ : IDLE;
                end else if (redirect) begin
                    // Memory still owes us this word; keep presenting its address.
                    squash_next = fetch_pc;
                    pc_next     = redirect_tgt;
                    state_next  = DROP;
                end
            end
            DROP: begin
                if (redirect) pc_next = redirect_tgt;
                if (imem_resp) state_next = has_space ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (if_valid),
        .head_entry (head_entry)
    );

    assign if_pc    = head_entry.pc;
    assign if_instr = head_entry.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, corner sequences and random
// traffic, all checked against a queue-based model of the fetch rules.
module tb_fetch_stage;

    localparam int QD = 2;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    fetch_stage #(.RESET_PC(32'h0000_0060), .QDEPTH(QD)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_0013;
    endfunction

    // Reference model: one outstanding request, a FIFO of fetched words.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_pc;

    task automatic model_reset();
        mq.delete();
        m_busy = 0;
        m_drop = 0;
        m_addr = 32'h0;
        m_pc   = 32'h0000_0060;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc, input bit rsp);
        bit kept;
        bit popped;
        kept   = m_busy && rsp && !m_drop && !rd;
        popped = (mq.size() > 0) && !st;
        if (rd) begin
            mq.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (popped) void'(mq.pop_front());
            if (kept) begin
                mq.push_back('{m_addr, mem_word(m_addr)});
                m_pc = m_addr + 32'd4;
            end
        end
        if (m_busy && rsp) m_busy = 0;
        else if (m_busy && rd) m_drop = 1;
        if (!m_busy && mq.size() < QD) begin
            m_busy = 1;
            m_drop = 0;
            m_addr = m_pc;
        end
    endtask

    // One clock: sample and check at the falling edge, then drive inputs.
    task automatic cycle(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                         input bit rsp, output logic o_read, output logic [31:0] o_addr,
                         output logic o_valid, output logic [31:0] o_pc);
        bit rsp_eff;
        @(negedge clk);
        rst = r;
        if (r) model_reset();
        #1;
        o_read  = imem_read;
        o_addr  = imem_address;
        o_valid = if_valid;
        o_pc    = if_pc;
        chk("imem_read", {31'd0, imem_read}, {31'd0, m_busy});
        if (m_busy) chk("imem_address", imem_address, m_addr);
        chk("if_valid", {31'd0, if_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_instr", if_instr, mq[0].instr);
        end
        if (r) begin
            chk("reset_if_pc", if_pc, 32'h0);
            chk("reset_if_instr", if_instr, 32'h0);
        end
        rsp_eff     = rsp && m_busy && !r;
        stall       = st;
        redirect    = rd && !r;
        redirect_pc = rpc;
        imem_resp   = rsp_eff;
        imem_rdata  = rsp_eff ? mem_word(m_addr) : $urandom;
        if (!r) model_step(st, rd && !r, rpc, rsp_eff);
    endtask

    typedef struct {
        bit          r;
        bit          st;
        bit          rsp;
        bit          e_read;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [16];

    logic        o_r;
    logic [31:0] o_a;
    logic        o_v;
    logic [31:0] o_p;

    initial begin
        rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0; imem_resp = 0; imem_rdata = 0;
        model_reset();

        // Zero-wait stream, reset mid-request, then stalled fill and drain.
        vt[0]  = '{1, 0, 0, 0, 32'h0,  0, 32'h0};
        vt[1]  = '{0, 0, 0, 0, 32'h0,  0, 32'h0};
        vt[2]  = '{0, 0, 1, 1, 32'h60, 0, 32'h0};
        vt[3]  = '{0, 0, 1, 1, 32'h64, 1, 32'h60};
        vt[4]  = '{0, 0, 1, 1, 32'h68, 1, 32'h64};
        vt[5]  = '{0, 0, 1, 1, 32'h6c, 1, 32'h68};
        vt[6]  = '{0, 0, 0, 1, 32'h70, 1, 32'h6c};
        vt[7]  = '{1, 0, 0, 0, 32'h0,  0, 32'h0};
        vt[8]  = '{0, 1, 0, 0, 32'h0,  0, 32'h0};
        vt[9]  = '{0, 1, 1, 1, 32'h60, 0, 32'h0};
        vt[10] = '{0, 1, 1, 1, 32'h64, 1, 32'h60};
        vt[11] = '{0, 1, 0, 0, 32'h0,  1, 32'h60};
        vt[12] = '{0, 0, 0, 0, 32'h0,  1, 32'h60};
        vt[13] = '{0, 0, 0, 1, 32'h68, 1, 32'h64};
        vt[14] = '{0, 0, 1, 1, 32'h68, 0, 32'h0};
        vt[15] = '{0, 0, 0, 1, 32'h6c, 1, 32'h68};

        for (int i = 0; i < 16; i++) begin
            cycle(vt[i].r, vt[i].st, 0, 32'h0, vt[i].rsp, o_r, o_a, o_v, o_p);
            chk($sformatf("vec%0d_read", i), {31'd0, o_r}, {31'd0, vt[i].e_read});
            if (vt[i].e_read) chk($sformatf("vec%0d_addr", i), o_a, vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'd0, o_v}, {31'd0, vt[i].e_valid});
            if (vt[i].e_valid) chk($sformatf("vec%0d_pc", i), o_p, vt[i].e_pc);
        end

        // Slow memory, redirect to 0x200 while 0x64 is outstanding.
        cycle(1, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 0, 0, 0, 1, o_r, o_a, o_v, o_p);
        cycle(0, 0, 1, 32'h200, 0, o_r, o_a, o_v, o_p);
        chk("slow_addr_before", o_a, 32'h64);
        cycle(0, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        chk("drop_hold_addr", o_a, 32'h64);
        chk("drop_flushed", {31'd0, o_v}, 32'h0);
        cycle(0, 0, 0, 0, 1, o_r, o_a, o_v, o_p);
        chk("drop_hold_addr2", o_a, 32'h64);
        cycle(0, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        chk("after_drop_addr", o_a, 32'h200);
        cycle(0, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 0, 0, 0, 1, o_r, o_a, o_v, o_p);
        chk("after_drop_nodata", {31'd0, o_v}, 32'h0);
        cycle(0, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        chk("after_drop_pc", o_p, 32'h200);

        // Redirect to 0x103 in the same cycle as the 0x68 response.
        cycle(1, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 0, 0, 0, 1, o_r, o_a, o_v, o_p);
        cycle(0, 0, 0, 0, 1, o_r, o_a, o_v, o_p);
        cycle(0, 0, 1, 32'h103, 1, o_r, o_a, o_v, o_p);
        chk("same_cycle_addr68", o_a, 32'h68);
        cycle(0, 0, 0, 0, 1, o_r, o_a, o_v, o_p);
        chk("same_cycle_next_addr", o_a, 32'h100);
        chk("same_cycle_flushed", {31'd0, o_v}, 32'h0);
        cycle(0, 0, 0, 0, 1, o_r, o_a, o_v, o_p);
        chk("same_cycle_next_pc", o_p, 32'h100);

        // Redirect with two entries queued under stall.
        cycle(1, 1, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 1, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 1, 0, 0, 1, o_r, o_a, o_v, o_p);
        cycle(0, 1, 0, 0, 1, o_r, o_a, o_v, o_p);
        cycle(0, 1, 1, 32'h300, 0, o_r, o_a, o_v, o_p);
        chk("full_no_read", {31'd0, o_r}, 32'h0);
        cycle(0, 1, 0, 0, 1, o_r, o_a, o_v, o_p);
        chk("stall_flush_valid", {31'd0, o_v}, 32'h0);
        chk("stall_flush_addr", o_a, 32'h300);
        cycle(0, 1, 0, 0, 0, o_r, o_a, o_v, o_p);
        chk("stall_flush_pc", o_p, 32'h300);

        // Fetch PC wraps past the top of the address space.
        cycle(1, 0, 0, 0, 0, o_r, o_a, o_v, o_p);
        cycle(0, 0, 1, 32'hFFFF_FFFE, 0, o_r, o_a, o_v, o_p);
        cycle(0, 0, 0, 0, 1, o_r, o_a, o_v, o_p);
        chk("wrap_addr_top", o_a, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 1, o_r, o_a, o_v, o_p);
        chk("wrap_addr_zero", o_a, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit st;
            bit rd;
            bit rsp;
            r   = ($urandom_range(0, 499) == 0);
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 99) < 8);
            rsp = ($urandom_range(0, 1) == 1);
            cycle(r, st, rd, $urandom, rsp, o_r, o_a, o_v, o_p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
